dm_dump_ctrl: RTL and testbench
===============================

// Module: dm_dump_ctrl
// PURPOSE
//  Debug-side reader for the MEM stage data memory. On a start request it walks every
//  data-memory address and streams each 32-bit word to the UART transmitter, one byte
//  per transfer. It drives the dm enable, dm read enable and dm read address inputs of
//  the MEM stage, and consumes the MEM stage debug word (byte_data).
// PARAMETERS
//  NB_DM_ADDR    7   data memory address width; depth = 2**NB_DM_ADDR words
//  MEMORY_WIDTH  32  dm word width; must be a multiple of NB_BYTE
//  NB_BYTE       8   UART payload width
// PORTS
//  i_clock           in   1             system clock
//  i_reset           in   1             synchronous, active-high reset
//  i_start           in   1             one-cycle dump request
//  o_dm_enable       out  1             to MEM stage dm enable
//  o_dm_read_enable  out  1             to MEM stage dm read enable (selects debug address)
//  o_dm_read_address out  NB_DM_ADDR    to MEM stage dm read address
//  i_dm_data         in   MEMORY_WIDTH  MEM stage byte_data; valid 1 cycle after address
//  i_tx_done         in   1             UART TX one-cycle pulse: byte finished
//  o_tx_start        out  1             one-cycle pulse: o_tx_data is valid, begin send
//  o_tx_data         out  NB_BYTE       byte to send; held stable from o_tx_start to i_tx_done
//  o_busy            out  1             high from the cycle after i_start until DONE
//  o_done            out  1             one-cycle pulse when the last byte has been sent
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; address, byte index and word register cleared.
//  - FSM states: IDLE, REQ, LATCH, SEND, WAIT_DONE, NEXT, DONE. All outputs registered.
//  - IDLE: i_start=1 -> REQ with addr=0. Otherwise stay in IDLE.
//    i_start while not IDLE is ignored, with no queueing.
//  - REQ: o_dm_enable=o_dm_read_enable=1, o_dm_read_address=addr -> LATCH.
//  - LATCH: word_reg <= i_dm_data; byte_idx <= 0 -> SEND.
//  - SEND: o_tx_data <= word_reg[byte_idx*8 +: 8]; o_tx_start=1 for this single cycle -> WAIT_DONE.
//  - WAIT_DONE: hold o_tx_data until i_tx_done=1.
//    If byte_idx = MEMORY_WIDTH/NB_BYTE-1 -> NEXT; else byte_idx++ -> SEND.
//  - NEXT: if addr = 2**NB_DM_ADDR-1 -> DONE; else addr++ -> REQ. There is no wrap-around.
//  - DONE: o_done=1 for one cycle; dm enables drop to 0 -> IDLE.
//  - Byte order: little endian, bits [7:0] are sent first.
//    Total bytes = 2**NB_DM_ADDR * MEMORY_WIDTH/NB_BYTE (512 at defaults).
//  - o_dm_enable and o_dm_read_enable stay high in every state from REQ through NEXT.
//    The address only changes in NEXT.
//  - i_tx_done outside WAIT_DONE is ignored. i_tx_done in the same cycle as o_tx_start is also ignored.
//  - Minimum gap between successive o_tx_start pulses is 2 cycles (WAIT_DONE -> SEND).
//  - Reset mid-dump: abort at the next edge and return to IDLE with all outputs 0.
//    A pending UART byte is not tracked.
// CONFIGURATION
//  DM_DUMP_HEADER_EN defined:
//    - Add states HDR0 and HDR1 between IDLE and REQ, each using the SEND/WAIT_DONE handshake.
//    - HDR0 sends 8'hA5; HDR1 sends the word count (2**NB_DM_ADDR)-1, i.e. 8'h7F at defaults.
//    - Total bytes = payload + 2.
//  DM_DUMP_HEADER_EN undefined: the first byte sent is word 0 bits [7:0]; no header states exist.
// TESTING
//  1. Reset: hold i_reset 3 cycles, mid-run -> all outputs 0 in the next cycle, state IDLE, o_busy=0.
//  2. Full dump: preload mem[0]=32'h11223344, mem[127]=32'hDEADBEEF; i_start; auto i_tx_done 10 cycles
//     after each o_tx_start -> first bytes 44,33,22,11; last bytes EF,BE,AD,DE;
//     exactly 512 o_tx_start pulses; o_done once.
//  3. Address sequence: o_dm_read_address steps 0..127 monotonically, changing only after 4 i_tx_done
//     pulses; o_dm_read_enable=1 throughout the dump.
//  4. Protocol abuse: i_start pulsed during the dump, and spurious i_tx_done in IDLE and in the SEND cycle
//     -> no restart, no skipped byte, byte count still 512.
//  5. Back-pressure: i_tx_done delayed 1000 cycles on byte 5 -> o_tx_data stays constant and
//     o_tx_start stays low for the whole delay.
//  6. (DM_DUMP_HEADER_EN) i_start -> first two bytes A5, 7F, then 44 (from mem[0]); 514 pulses total.

Source files
------------

// File: rtl/dm_dump_ctrl.sv
// Streams every data-memory word to the UART, one byte per handshake, little endian.
// Latency: first o_tx_start 3 cycles after i_start (REQ, LATCH, SEND); optional 2-byte header with DM_DUMP_HEADER_EN.
// Backpressure: each byte is held on o_tx_data until i_tx_done; nothing advances while the UART is busy.
module dm_dump_ctrl #(
    parameter int NB_DM_ADDR   = 7,
    parameter int MEMORY_WIDTH = 32,
    parameter int NB_BYTE      = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    output logic                    o_dm_enable,
    output logic                    o_dm_read_enable,
    output logic [NB_DM_ADDR-1:0]   o_dm_read_address,
    input  logic [MEMORY_WIDTH-1:0] i_dm_data,
    input  logic                    i_tx_done,
    output logic                    o_tx_start,
    output logic [NB_BYTE-1:0]      o_tx_data,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int BYTES_PER_WORD = MEMORY_WIDTH / NB_BYTE;
    localparam int NB_IDX         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [NB_IDX-1:0]     LAST_BYTE = NB_IDX'(BYTES_PER_WORD - 1);
    localparam logic [NB_DM_ADDR-1:0] LAST_ADDR = '1;

`ifdef DM_DUMP_HEADER_EN
    localparam logic [NB_BYTE-1:0] HDR_SYNC  = NB_BYTE'(8'hA5);
    localparam logic [NB_BYTE-1:0] HDR_COUNT = NB_BYTE'((2 ** NB_DM_ADDR) - 1);

    typedef enum logic [3:0] {
        IDLE, REQ, LATCH, SEND, WAIT_DONE, NEXT, DONE, HDR0, HDR1
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, REQ, LATCH, SEND, WAIT_DONE, NEXT, DONE
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [NB_DM_ADDR-1:0]   addr_q, addr_d;
    logic [NB_IDX-1:0]       byte_idx_q, byte_idx_d;
    logic [MEMORY_WIDTH-1:0] word_q, word_d;
    logic [NB_BYTE-1:0]      tx_data_q, tx_data_d;
    logic                    tx_start_q, tx_start_d;
    logic                    dm_en_q, dm_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
`ifdef DM_DUMP_HEADER_EN
    // 0: payload, 1: waiting on HDR0 byte, 2: waiting on HDR1 byte
    logic [1:0]              hdr_q, hdr_d;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            dm_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DM_DUMP_HEADER_EN
            hdr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            dm_en_q    <= dm_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DM_DUMP_HEADER_EN
            hdr_q      <= hdr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
`ifdef DM_DUMP_HEADER_EN
        hdr_d      = hdr_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    addr_d     = '0;
                    byte_idx_d = '0;
`ifdef DM_DUMP_HEADER_EN
                    state_d    = HDR0;
`else
                    state_d    = REQ;
`endif
                end
            end
`ifdef DM_DUMP_HEADER_EN
            HDR0: begin
                hdr_d   = 2'd1;
                state_d = WAIT_DONE;
            end
            HDR1: begin
                hdr_d   = 2'd2;
                state_d = WAIT_DONE;
            end
`endif
            REQ:   state_d = LATCH;
            LATCH: begin
                word_d     = i_dm_data;
                byte_idx_d = '0;
                state_d    = SEND;
            end
            // Send cycle: a done pulse coinciding with tx_start is deliberately not looked at.
            SEND:  state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (i_tx_done) begin
`ifdef DM_DUMP_HEADER_EN
                    if (hdr_q == 2'd1) begin
                        state_d = HDR1;
                    end else if (hdr_q == 2'd2) begin
                        hdr_d   = 2'd0;
                        state_d = REQ;
                    end else
`endif
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = NEXT;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = SEND;
                    end
                end
            end
            NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        dm_en_d    = 1'b0;
        busy_d     = (state_d != IDLE) && (state_d != DONE);
        done_d     = (state_d == DONE);
        case (state_d)
            SEND: begin
                tx_start_d = 1'b1;
                tx_data_d  = word_d[int'(byte_idx_d) * NB_BYTE +: NB_BYTE];
                dm_en_d    = 1'b1;
            end
`ifdef DM_DUMP_HEADER_EN
            HDR0: begin
                tx_start_d = 1'b1;
                tx_data_d  = HDR_SYNC;
            end
            HDR1: begin
                tx_start_d = 1'b1;
                tx_data_d  = HDR_COUNT;
            end
            WAIT_DONE: dm_en_d = (hdr_d == 2'd0);
`else
            WAIT_DONE: dm_en_d = 1'b1;
`endif
            REQ, LATCH, NEXT: dm_en_d = 1'b1;
            default: dm_en_d = 1'b0;
        endcase
    end

    assign o_dm_enable       = dm_en_q;
    assign o_dm_read_enable  = dm_en_q;
    assign o_dm_read_address = addr_q;
    assign o_tx_start        = tx_start_q;
    assign o_tx_data         = tx_data_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;

endmodule

// File: tb/tb_dm_dump_ctrl.sv
// Bench for dm_dump_ctrl: random memory image, UART responder with variable delays, byte-stream scoreboard.
module tb_dm_dump_ctrl;

    localparam int NB_DM_ADDR = 7;
    localparam int DEPTH      = 2 ** NB_DM_ADDR;
    localparam int BPW        = 4;
`ifdef DM_DUMP_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif
    localparam int TOTAL = DEPTH * BPW + HDR;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_tx_done = 1'b0;
    logic [31:0] dm_data = '0;
    logic        o_dm_enable, o_dm_read_enable, o_tx_start, o_busy, o_done;
    logic [6:0]  o_dm_read_address;
    logic [7:0]  o_tx_data;

    logic [31:0] mem [DEPTH];
    logic [7:0]  exp_q [$];
    int          errors = 0;
    int          checks = 0;

    dm_dump_ctrl #(.NB_DM_ADDR(NB_DM_ADDR), .MEMORY_WIDTH(32), .NB_BYTE(8)) dut (
        .i_clock          (clk),
        .i_reset          (i_reset),
        .i_start          (i_start),
        .o_dm_enable      (o_dm_enable),
        .o_dm_read_enable (o_dm_read_enable),
        .o_dm_read_address(o_dm_read_address),
        .i_dm_data        (dm_data),
        .i_tx_done        (i_tx_done),
        .o_tx_start       (o_tx_start),
        .o_tx_data        (o_tx_data),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    always #5 clk = ~clk;

    // MEM stage model: synchronous read, data valid the cycle after the address.
    always @(posedge clk)
        if (o_dm_enable && o_dm_read_enable) dm_data <= mem[o_dm_read_address];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({o_dm_enable, o_dm_read_enable, o_dm_read_address, o_tx_start,
                    o_tx_data, o_busy, o_done});
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0]       = 32'h1122_3344;
        mem[DEPTH-1] = 32'hDEAD_BEEF;
    endtask

    // Expected stream: optional header, then every word least-significant byte first.
    task automatic build_expected();
        logic [31:0] w;
        exp_q.delete();
        if (HDR != 0) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(DEPTH - 1));
        end
        for (int a = 0; a < DEPTH; a++) begin
            w = mem[a];
            for (int b = 0; b < BPW; b++) exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic run_dump(input int slow_byte, input int slow_delay,
                            input bit rand_delay, input bit abuse);
        int idx = 0, cnt_done = 0, countdown = 0, post = 0, cyc = 0;
        int en_drop = 0, hold_err = 0, last_addr = 0;
        bit waiting = 0, en_started = 0, finished = 0;
        logic [7:0] held = '0;
        build_expected();
        @(negedge clk);
        i_start = 1'b1;
        while (!finished) begin
            @(negedge clk);
            i_start   = 1'b0;
            i_tx_done = 1'b0;
            cyc++;
            if (cyc == 1) chk("busy_start", o_busy, 1);
            if (o_tx_start) begin
                chk("no_overlap", waiting, 0);
                if (idx < TOTAL) chk($sformatf("byte%0d", idx), o_tx_data, exp_q[idx]);
                held    = o_tx_data;
                waiting = 1'b1;
                if (idx == slow_byte) countdown = slow_delay;
                else if (rand_delay)  countdown = $urandom_range(1, 12);
                else                  countdown = 10;
                idx++;
                if (abuse && (idx % 64 == 7)) i_tx_done = 1'b1;
                if (abuse && idx == 200) i_start = 1'b1;
            end else if (waiting) begin
                if (o_tx_data !== held) hold_err++;
                countdown--;
                if (countdown == 0) begin
                    i_tx_done = 1'b1;
                    waiting   = 1'b0;
                end
            end
            if (o_done) cnt_done++;
            if (o_dm_read_enable) begin
                if (!en_started) begin
                    en_started = 1'b1;
                    chk("addr_first", o_dm_read_address, 0);
                end else if (int'(o_dm_read_address) != last_addr) begin
                    chk("addr_step", o_dm_read_address, last_addr + 1);
                    chk("addr_after_bytes", idx, HDR + BPW * int'(o_dm_read_address));
                end
                last_addr = int'(o_dm_read_address);
            end else if (en_started && cnt_done == 0) begin
                en_drop++;
            end
            if (cnt_done > 0) post++;
            if (post > 20) finished = 1'b1;
            if (cyc > 40000) begin
                chk("timeout", 0, 1);
                finished = 1'b1;
            end
        end
        chk("tx_pulses", idx, TOTAL);
        chk("done_count", cnt_done, 1);
        chk("last_addr", last_addr, DEPTH - 1);
        chk("rd_en_gap", en_drop, 0);
        chk("hold_stable", hold_err, 0);
        chk("busy_end", o_busy, 0);
    endtask

    initial begin
        int acc;
        fill_mem();
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        i_reset = 1'b0;

        // Spurious done while idle must not start anything.
        @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        chk("idle_tx_start", o_tx_start, 0);
        chk("idle_busy", o_busy, 0);

        run_dump(5, 1000, 1'b0, 1'b1);

        // Reset in the middle of a dump.
        fill_mem();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (300) begin
            @(negedge clk);
            i_tx_done = (!o_tx_start) && ($urandom_range(0, 3) == 0);
        end
        chk("busy_mid", o_busy, 1);
        i_tx_done = 1'b0;
        i_reset   = 1'b1;
        @(negedge clk);
        chk("mid_reset_outs", all_outs(), 0);
        i_reset = 1'b0;
        acc = 0;
        repeat (30) begin
            @(negedge clk);
            acc += int'(o_tx_start) + int'(o_busy) + int'(o_dm_enable);
        end
        chk("idle_after_reset", acc, 0);

        run_dump(-1, 0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
